// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings
// and the helper that sizes the step counter from the operand width.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SIZE_DEFAULT = 16;

    function automatic int step_cnt_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the divider; the master drives operands, the
// slave (divider) returns the busy/done handshake and the results.
interface seq_divider_if #(parameter int SIZE = seq_divider_pkg::SIZE_DEFAULT) ();

    logic            iStart;
    logic [SIZE-1:0] iDividend;
    logic [SIZE-1:0] iDivisor;
    logic            oBusy;
    logic            oDone;
    logic [SIZE-1:0] oQuotient;
    logic [SIZE-1:0] oRemainder;
    logic            oDivByZero;

    modport master (
        output iStart, iDividend, iDivisor,
        input  oBusy, oDone, oQuotient, oRemainder, oDivByZero
    );

    modport slave (
        input  iStart, iDividend, iDivisor,
        output oBusy, oDone, oQuotient, oRemainder, oDivByZero
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: compare the shifted partial remainder with
// the divisor at SIZE+1 bits and subtract when it fits.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic [SIZE:0]   rem_shifted,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE:0]   rem_next,
    output logic            q_bit
);

    logic [SIZE:0] divisor_ext;
    logic [SIZE:0] diff;

    assign divisor_ext = {1'b0, divisor};
    assign diff        = rem_shifted - divisor_ext;
    assign q_bit       = (rem_shifted >= divisor_ext);
    assign rem_next    = q_bit ? diff : rem_shifted;

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential divider: one quotient bit per clock, MSB first,
// divide-by-zero short-circuits straight to DONE.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic          Clock,
    input  logic          Reset,
    seq_divider_if.slave  bus
);

    localparam int             CW        = step_cnt_width(SIZE);
    localparam logic [CW-1:0]  LAST_STEP = CW'(SIZE - 1);

    state_t          state, state_next;
    logic [CW-1:0]   step;
    logic [SIZE-1:0] dividend_q;
    logic [SIZE-1:0] divisor_q;
    logic [SIZE-1:0] quot_acc;
    logic [SIZE:0]   part_rem;
    logic [SIZE:0]   rem_shifted;
    logic [SIZE:0]   rem_next;
    logic            q_bit;
    logic [SIZE-1:0] quotient_r;
    logic [SIZE-1:0] remainder_r;
    logic            div_by_zero_r;
    logic            accept;
    logic            accept_zero;
    logic            last_step;
    logic            rem_msb_unused;

    // A remainder never exceeds the divisor, so the top partial-remainder bit is always 0.
    assign rem_shifted    = {part_rem[SIZE-1:0], dividend_q[SIZE-1]};
    assign rem_msb_unused = part_rem[SIZE];

    div_step #(.SIZE(SIZE)) u_step (
        .rem_shifted (rem_shifted),
        .divisor     (divisor_q),
        .rem_next    (rem_next),
        .q_bit       (q_bit)
    );

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        accept_zero = 1'b0;
        last_step   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.iStart) begin
                    if (bus.iDivisor == '0) begin
                        accept_zero = 1'b1;
                        state_next  = ST_DONE;
                    end else begin
                        accept      = 1'b1;
                        state_next  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (step == LAST_STEP) begin
                    last_step  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Results only change when DONE is entered, so RUN never exposes partial values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= ST_IDLE;
            step          <= '0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            quot_acc      <= '0;
            part_rem      <= '0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                dividend_q <= bus.iDividend;
                divisor_q  <= bus.iDivisor;
                quot_acc   <= '0;
                part_rem   <= '0;
                step       <= '0;
            end
            if (accept_zero) begin
                quotient_r    <= '1;
                remainder_r   <= bus.iDividend;
                div_by_zero_r <= 1'b1;
            end
            if (state == ST_RUN) begin
                part_rem   <= rem_next;
                dividend_q <= {dividend_q[SIZE-2:0], 1'b0};
                quot_acc   <= {quot_acc[SIZE-2:0], q_bit};
                step       <= step + CW'(1);
                if (last_step) begin
                    quotient_r    <= {quot_acc[SIZE-2:0], q_bit};
                    remainder_r   <= rem_next[SIZE-1:0];
                    div_by_zero_r <= 1'b0;
                end
            end
        end
    end

    assign bus.oBusy      = (state != ST_IDLE);
    assign bus.oDone      = (state == ST_DONE);
    assign bus.oQuotient  = quotient_r;
    assign bus.oRemainder = remainder_r;
    assign bus.oDivByZero = div_by_zero_r;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter SIZE, default 16, operand/result width in bits; legal range 4..32.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 iStart  input  1  request to begin a division; sampled on the rising edge of Clock.
REQ-005 iDividend  input  SIZE  unsigned dividend; sampled only on the edge that accepts iStart.
REQ-006 iDivisor  input  SIZE  unsigned divisor; sampled only on the edge that accepts iStart.
REQ-007 oBusy  output  1  high whenever state is not IDLE.
REQ-008 oDone  output  1  one-cycle pulse marking valid results.
REQ-009 oQuotient  output  SIZE  unsigned quotient of the last completed division.
REQ-010 oRemainder  output  SIZE  unsigned remainder of the last completed division.
REQ-011 oDivByZero  output  1  high when the last completed division had divisor 0.

Function
REQ-012 Algorithm: restoring shift-subtract, unsigned, one quotient bit per clock, MSB first.
REQ-013 FSM states: IDLE, RUN, DONE; no other reachable states.
REQ-014 IDLE and iStart=1 and iDivisor!=0 -> latch operands, clear partial remainder, clear step counter, go to RUN.
REQ-015 IDLE and iStart=1 and iDivisor=0 -> go to DONE directly; results: quotient all-ones, remainder = iDividend, oDivByZero=1.
REQ-016 RUN step: partial remainder (SIZE+1 bits) shifted left by 1, next dividend bit enters the LSB; if result >= divisor, subtract divisor and shift quotient bit 1, else shift in 0.
REQ-017 Compare/subtract performed at SIZE+1 bits; no truncation or overflow for any divisor value.
REQ-018 Step counter counts 0..SIZE-1; on the edge completing step SIZE-1 -> DONE.
REQ-019 Latency: oDone high in the cycle following edge N+SIZE, N being the edge that accepted iStart (N+1 for divide-by-zero).
REQ-020 Entering DONE: oQuotient, oRemainder and oDivByZero load simultaneously; oDone=1.
REQ-021 DONE -> IDLE on the next edge unconditionally; oDone returns to 0; results held until the next DONE entry.
REQ-022 oQuotient/oRemainder/oDivByZero keep the previous result throughout RUN; no intermediate values are visible.
REQ-023 iStart while in RUN or DONE is ignored; no queuing; operand inputs are don't-care outside the accepting edge.
REQ-024 Back-to-back: iStart held high continuously -> new division accepted on the first edge back in IDLE.
REQ-025 Divisor 1 -> quotient = dividend, remainder 0; dividend < divisor -> quotient 0, remainder = dividend.

Reset
REQ-026 Reset=1 at an edge: state IDLE, oBusy=0, oDone=0, oQuotient=0, oRemainder=0, oDivByZero=0, counter=0.
REQ-027 Reset has priority over iStart and over any in-progress division; an aborted division never produces oDone.
REQ-028 Initial state after configuration is undefined until the first Reset edge.

Structure
REQ-029 FSM state encodings and the step-counter width (clog2 of SIZE) go in the team's shared include/package; no literals in the RTL body.
REQ-030 One sub-module, div_step: combinational SIZE+1-bit compare/subtract producing next partial remainder and quotient bit; instantiated once.
REQ-031 All state registers in one clocked process; no latches; no combinational path from inputs to outputs.

Verification
REQ-032 Start 100/7 (SIZE=16) -> oDone exactly 16 cycles after the accept edge, Q=14, R=2, oDivByZero=0.
REQ-033 Start 0xFFFF/0x0001 then 0xFFFF/0xFFFF -> Q=0xFFFF,R=0 then Q=0x0001,R=0.
REQ-034 Start 5/0 -> oDone on the cycle after accept, Q=0xFFFF, R=5, oDivByZero=1; next 9/3 clears it (Q=3,R=0,flag 0).
REQ-035 Start 3/10, pulse iStart with 50/5 at cycle 4 of RUN -> second request ignored, Q=0, R=3, single oDone.
REQ-036 Start 1000/33, assert Reset at cycle 8 of RUN -> no oDone, all outputs 0, oBusy=0 next cycle; then 1000/33 -> Q=30, R=10.
REQ-037 Random self-check, 1000 operand pairs incl. 0 and all-ones, iStart held high -> each result matches the / and % reference model.
